// File: rtl/sdram_wb_tester_pkg.sv
// Shared types and constants for the SDRAM Wishbone memory tester.
// FSM state encoding, run-mode codes, bus select value and the LFSR step.
package sdram_wb_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_GAP = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_GAP = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [1:0]  MODE_FILL       = 2'b00;
  localparam logic [1:0]  MODE_CHECK      = 2'b01;
  localparam logic [1:0]  MODE_FILL_CHECK = 2'b10;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [3:0]  SEL_ALL   = 4'hF;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    logic [31:0] shifted;
    shifted = {1'b0, cur[31:1]};
    if (cur[0]) begin
      return shifted ^ LFSR_TAPS;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/sdram_wb_tester_patgen.sv
// Pattern generator for the memory tester. Holds the seed and produces the
// current pattern word; the FSM only says load / restart / advance.
// Build option: SDRAM_WB_TESTER_LFSR_EN selects a 32-bit Galois LFSR
// sequence instead of the default incrementing seed+index sequence.
module sdram_wb_tester_patgen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        restart,
  input  logic        advance,
  output logic [31:0] pattern
);
  import sdram_wb_tester_pkg::*;

  logic [31:0] seed_r;
  logic [31:0] pat_r;
  logic [31:0] pat_next_s;

`ifdef SDRAM_WB_TESTER_LFSR_EN
  // An all-zero LFSR state would lock up, so seed 0 starts from 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    if (s == 32'h0000_0000) begin
      return 32'h0000_0001;
    end else begin
      return s;
    end
  endfunction

  assign pat_next_s = lfsr_next(pat_r);
`else
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return s;
  endfunction

  assign pat_next_s = pat_r + 32'h0000_0001;
`endif

  // Seed capture on a new run, reload at each pass, step once per word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_r <= 32'h0000_0000;
      pat_r  <= 32'h0000_0000;
    end else if (load) begin
      seed_r <= seed;
      pat_r  <= seed_fix(seed);
    end else if (restart) begin
      pat_r  <= seed_fix(seed_r);
    end else if (advance) begin
      pat_r  <= pat_next_s;
    end
  end

  assign pattern = pat_r;

endmodule

// File: rtl/sdram_wb_tester.sv
// Wishbone classic master that fills and/or checks a word range of the
// SDRAM slave with a deterministic pattern, counting miscompares and
// aborting a run when the slave does not acknowledge in time.
// Build option: SDRAM_WB_TESTER_LFSR_EN (pattern source, see patgen).
module sdram_wb_tester #(
  parameter int LEN_W       = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [1:0]       cfg_mode,
  input  logic [31:0]      cfg_base,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [31:0]      cfg_seed,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic [31:0]      first_err_addr,
  output logic             timeout_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);
  import sdram_wb_tester_pkg::*;

  localparam logic [7:0]       TO_LAST = 8'(ACK_TIMEOUT - 1);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e           state_r;
  state_e           state_nxt_s;

  logic [1:0]       mode_r;
  logic [31:0]      base_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] index_r;
  logic [7:0]       to_cnt_r;

  logic             cyc_r;
  logic             we_r;
  logic [3:0]       sel_r;
  logic [31:0]      adr_r;
  logic             busy_r;
  logic             done_r;
  logic [ERR_W-1:0] err_cnt_r;
  logic [31:0]      first_err_r;
  logic             timeout_r;

  logic             start_acc_s;
  logic             restart_pass_s;
  logic             step_s;
  logic             rd_ack_s;
  logic             timeout_s;
  logic             last_s;
  logic [31:0]      pat_s;

  assign last_s = (index_r == (len_r - ONE_LEN));

  sdram_wb_tester_patgen u_patgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_acc_s),
    .seed    (cfg_seed),
    .restart (restart_pass_s),
    .advance (step_s),
    .pattern (pat_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_nxt_s    = state_r;
    start_acc_s    = 1'b0;
    restart_pass_s = 1'b0;
    step_s         = 1'b0;
    rd_ack_s       = 1'b0;
    timeout_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) begin
          start_acc_s = 1'b1;
          if (cfg_len == {LEN_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else if (cfg_mode == MODE_CHECK) begin
            state_nxt_s = ST_RD_REQ;
          end else begin
            state_nxt_s = ST_WR_REQ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (wbm_ack_i) begin
          state_nxt_s = ST_WR_GAP;
        end else if (to_cnt_r == TO_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WR_REQ;
        end
      end
      ST_WR_GAP: begin
        if (last_s) begin
          if (mode_r == MODE_FILL_CHECK) begin
            restart_pass_s = 1'b1;
            state_nxt_s    = ST_RD_REQ;
          end else begin
            state_nxt_s    = ST_DONE;
          end
        end else begin
          step_s      = 1'b1;
          state_nxt_s = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        if (wbm_ack_i) begin
          rd_ack_s    = 1'b1;
          state_nxt_s = ST_RD_GAP;
        end else if (to_cnt_r == TO_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RD_REQ;
        end
      end
      ST_RD_GAP: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          step_s      = 1'b1;
          state_nxt_s = ST_RD_REQ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Run configuration, word index/address, ack timer and result tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r      <= 2'b00;
      base_r      <= 32'h0000_0000;
      len_r       <= {LEN_W{1'b0}};
      index_r     <= {LEN_W{1'b0}};
      adr_r       <= 32'h0000_0000;
      to_cnt_r    <= 8'h00;
      err_cnt_r   <= {ERR_W{1'b0}};
      first_err_r <= 32'h0000_0000;
      timeout_r   <= 1'b0;
    end else begin
      if ((state_r == ST_WR_REQ) || (state_r == ST_RD_REQ)) begin
        to_cnt_r <= to_cnt_r + 8'h01;
      end else begin
        to_cnt_r <= 8'h00;
      end

      if (start_acc_s) begin
        mode_r      <= cfg_mode;
        base_r      <= cfg_base & 32'hFFFF_FFFC;
        len_r       <= cfg_len;
        index_r     <= {LEN_W{1'b0}};
        adr_r       <= cfg_base & 32'hFFFF_FFFC;
        err_cnt_r   <= {ERR_W{1'b0}};
        first_err_r <= 32'h0000_0000;
        timeout_r   <= 1'b0;
      end else if (restart_pass_s) begin
        index_r <= {LEN_W{1'b0}};
        adr_r   <= base_r;
      end else if (step_s) begin
        index_r <= index_r + ONE_LEN;
        adr_r   <= adr_r + 32'h0000_0004;
      end

      if (rd_ack_s && (wbm_dat_i != pat_s)) begin
        if (err_cnt_r == {ERR_W{1'b0}}) begin
          first_err_r <= adr_r;
        end
        if (err_cnt_r != ERR_MAX) begin
          err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
        end
      end

      if (timeout_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  // Bus and status outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r  <= 1'b0;
      we_r   <= 1'b0;
      sel_r  <= 4'h0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      cyc_r  <= (state_nxt_s == ST_WR_REQ) || (state_nxt_s == ST_RD_REQ);
      we_r   <= (state_nxt_s == ST_WR_REQ);
      sel_r  <= (state_nxt_s == ST_WR_REQ) ? SEL_ALL : 4'h0;
      busy_r <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign wbm_cyc_o      = cyc_r;
  assign wbm_stb_o      = cyc_r;
  assign wbm_we_o       = we_r;
  assign wbm_sel_o      = sel_r;
  assign wbm_adr_o      = adr_r;
  assign wbm_dat_o      = pat_s;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err_cnt        = err_cnt_r;
  assign first_err_addr = first_err_r;
  assign timeout_err    = timeout_r;

endmodule

// File: tb/tb_sdram_wb_tester.sv
// Directed bench for sdram_wb_tester with a small Wishbone slave model.
module tb_sdram_wb_tester;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [1:0]  cfg_mode = 2'b00;
  logic [31:0] cfg_base = 32'h0;
  logic [15:0] cfg_len = 16'h0;
  logic [31:0] cfg_seed = 32'h0;
  logic        busy, done, timeout_err;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;

  sdram_wb_tester dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .timeout_err(timeout_err), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  // Slave model controls (written only by the stimulus block).
  int          ack_lat = 2;
  logic        ack_en = 1'b1;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_adr = 32'h0;

  // Slave model state (written only by the slave process).
  logic [31:0] mem [0:255];
  int          lat_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];

  // Slave: registered ack ack_lat cycles into each request, one-cycle ack.
  always @(posedge clk) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && ack_en) begin
      if (lat_cnt >= ack_lat - 1) begin
        wbm_ack_i <= 1'b1;
        lat_cnt   <= 0;
        if (wbm_we_o) begin
          mem[wbm_adr_o[9:2]] <= wbm_dat_o;
          wr_adr_q.push_back(wbm_adr_o);
          wr_dat_q.push_back(wbm_dat_o);
        end else begin
          rd_cnt <= rd_cnt + 1;
          if (corrupt_en && (wbm_adr_o == corrupt_adr)) begin
            wbm_dat_i <= 32'hDEAD_BEEF;
          end else begin
            wbm_dat_i <= mem[wbm_adr_o[9:2]];
          end
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      wbm_ack_i <= 1'b0;
      lat_cnt   <= 0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected pattern word for a given seed and word index.
  function automatic logic [31:0] pat_model(input logic [31:0] seed, input int idx);
    logic [31:0] p;
`ifdef SDRAM_WB_TESTER_LFSR_EN
    p = (seed == 32'h0) ? 32'h1 : seed;
    for (int k = 0; k < idx; k++) begin
      p = p[0] ? ({1'b0, p[31:1]} ^ 32'h8020_0003) : {1'b0, p[31:1]};
    end
`else
    p = seed + 32'(idx);
`endif
    return p;
  endfunction

  // Per-run observations gathered at negedges.
  int   rises, max_run, gap_min, gap_max, done_pulses, viol, done_at;
  logic busy_first;

  task automatic run_cfg(input logic [1:0] mode, input logic [31:0] base,
                         input logic [15:0] len, input logic [31:0] seed,
                         input int restart_at, input int max_cyc);
    logic prev_cyc;
    int   run;
    int   gap;
    rises = 0; max_run = 0; gap_min = 1000; gap_max = 0;
    done_pulses = 0; viol = 0; done_at = -1;
    @(negedge clk);
    cfg_mode = mode; cfg_base = base; cfg_len = len; cfg_seed = seed;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    busy_first = busy;
    prev_cyc = 1'b0; run = 0; gap = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (wbm_stb_o !== wbm_cyc_o) viol++;
      if (wbm_cyc_o && wbm_we_o && (wbm_sel_o !== 4'hF)) viol++;
      if (wbm_cyc_o && !wbm_we_o && (wbm_sel_o !== 4'h0)) viol++;
      if (wbm_cyc_o) begin
        if (!prev_cyc) begin
          rises++;
          if (gap > 0) begin
            if (gap < gap_min) gap_min = gap;
            if (gap > gap_max) gap_max = gap;
          end
          gap = 0;
          run = 0;
        end
        run++;
        if (run > max_run) max_run = run;
      end else if (busy) begin
        gap++;
      end
      if (done) begin
        done_pulses++;
        if (done_at < 0) done_at = i;
      end
      prev_cyc = wbm_cyc_o;
      if ((restart_at > 0) && (i == restart_at)) begin
        cfg_mode = 2'b01; cfg_base = 32'h0000_0400; cfg_len = 16'd7;
        cfg_seed = 32'h0000_00AA; cfg_start = 1'b1;
      end else begin
        cfg_start = 1'b0;
      end
      if ((done_at >= 0) && (i >= done_at + 8)) break;
      @(negedge clk);
    end
    cfg_start = 1'b0;
    chk("run_done_seen", 64'(done_at >= 0), 64'd1);
  endtask

  int wr_base;
  int rd_base;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("rst_stb", 64'(wbm_stb_o), 64'd0);
    chk("rst_we", 64'(wbm_we_o), 64'd0);
    chk("rst_sel", 64'(wbm_sel_o), 64'd0);
    chk("rst_adr", 64'(wbm_adr_o), 64'd0);
    chk("rst_dat", 64'(wbm_dat_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_ferr", 64'(first_err_addr), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill-then-check, 4 words at 0x100, seed 0x10000000
    wr_base = wr_adr_q.size(); rd_base = rd_cnt;
    run_cfg(2'b10, 32'h0000_0100, 16'd4, 32'h1000_0000, 0, 200);
    chk("fc_busy_first", 64'(busy_first), 64'd1);
    chk("fc_nwr", 64'(wr_adr_q.size() - wr_base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fc_wr_adr", 64'(wr_adr_q[wr_base + i]), 64'(32'h100 + 32'(4 * i)));
      chk("fc_wr_dat", 64'(wr_dat_q[wr_base + i]), 64'(pat_model(32'h1000_0000, i)));
    end
`ifndef SDRAM_WB_TESTER_LFSR_EN
    chk("fc_wr_dat3_hand", 64'(wr_dat_q[wr_base + 3]), 64'h1000_0003);
`endif
    chk("fc_nrd", 64'(rd_cnt - rd_base), 64'd4);
    chk("fc_err", 64'(err_cnt), 64'd0);
    chk("fc_done_pulses", 64'(done_pulses), 64'd1);
    chk("fc_rises", 64'(rises), 64'd8);
    chk("fc_gap_min", 64'(gap_min), 64'd1);
    chk("fc_gap_max", 64'(gap_max), 64'd1);
    chk("fc_proto", 64'(viol), 64'd0);
    chk("fc_busy_end", 64'(busy), 64'd0);

    // Check-only pass with the word at 0x108 corrupted
    corrupt_en = 1'b1; corrupt_adr = 32'h0000_0108;
    wr_base = wr_adr_q.size(); rd_base = rd_cnt;
    run_cfg(2'b01, 32'h0000_0100, 16'd4, 32'h1000_0000, 0, 200);
    corrupt_en = 1'b0;
    chk("ck_nwr", 64'(wr_adr_q.size() - wr_base), 64'd0);
    chk("ck_nrd", 64'(rd_cnt - rd_base), 64'd4);
    chk("ck_err", 64'(err_cnt), 64'd1);
    chk("ck_ferr", 64'(first_err_addr), 64'h108);
    chk("ck_done_pulses", 64'(done_pulses), 64'd1);

    // Slave never acks: abort after 255 request cycles
    ack_en = 1'b0;
    run_cfg(2'b00, 32'h0000_0200, 16'd3, 32'h0000_0001, 0, 400);
    ack_en = 1'b1;
    chk("to_max_run", 64'(max_run), 64'd255);
    chk("to_rises", 64'(rises), 64'd1);
    chk("to_flag", 64'(timeout_err), 64'd1);
    chk("to_done_pulses", 64'(done_pulses), 64'd1);
    chk("to_err", 64'(err_cnt), 64'd0);
    chk("to_ferr_clr", 64'(first_err_addr), 64'd0);

    // Zero-length run: done on the second cycle, no bus cycle
    run_cfg(2'b00, 32'h0000_0300, 16'd0, 32'h0000_0001, 0, 20);
    chk("z_done_at", 64'(done_at), 64'd0);
    chk("z_rises", 64'(rises), 64'd0);
    chk("z_busy_first", 64'(busy_first), 64'd0);
    chk("z_tmo_clr", 64'(timeout_err), 64'd0);

    // Start re-pulsed while busy is ignored
    wr_base = wr_adr_q.size(); rd_base = rd_cnt;
    run_cfg(2'b00, 32'h0000_0300, 16'd2, 32'h0000_0055, 2, 200);
    chk("rb_nwr", 64'(wr_adr_q.size() - wr_base), 64'd2);
    chk("rb_adr0", 64'(wr_adr_q[wr_base]), 64'h300);
    chk("rb_adr1", 64'(wr_adr_q[wr_base + 1]), 64'h304);
    chk("rb_dat1", 64'(wr_dat_q[wr_base + 1]), 64'(pat_model(32'h55, 1)));
    chk("rb_nrd", 64'(rd_cnt - rd_base), 64'd0);
    chk("rb_done_pulses", 64'(done_pulses), 64'd1);

    // Asynchronous reset in the middle of a write request
    ack_lat = 10;
    @(negedge clk);
    cfg_mode = 2'b00; cfg_base = 32'h0000_0100; cfg_len = 16'd4;
    cfg_seed = 32'h0000_0001; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("ar_pre_cyc", 64'(wbm_cyc_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("ar_stb", 64'(wbm_stb_o), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("ar_idle_cyc", 64'(wbm_cyc_o), 64'd0);
    chk("ar_idle_busy", 64'(busy), 64'd0);
    ack_lat = 2;
    wr_base = wr_adr_q.size();
    run_cfg(2'b00, 32'h0000_0500, 16'd1, 32'h0000_0077, 0, 100);
    chk("ar_after_nwr", 64'(wr_adr_q.size() - wr_base), 64'd1);
    chk("ar_after_adr", 64'(wr_adr_q[wr_base]), 64'h500);

`ifdef SDRAM_WB_TESTER_LFSR_EN
    // LFSR sequence from seed 0, fill then check
    wr_base = wr_adr_q.size();
    run_cfg(2'b10, 32'h0000_0100, 16'd3, 32'h0000_0000, 0, 200);
    chk("lf_w0", 64'(wr_dat_q[wr_base]), 64'h0000_0001);
    chk("lf_w1", 64'(wr_dat_q[wr_base + 1]), 64'h8020_0003);
    chk("lf_w2", 64'(wr_dat_q[wr_base + 2]), 64'hC030_0002);
    chk("lf_err", 64'(err_cnt), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
